// File: rtl/sparrow_pkg.sv
// Shared types for the sparrow core: memory access sizes and LSU states.
package sparrow_pkg;

    typedef enum logic [1:0] {
        BYTE        = 2'd0,
        HALF_WORD   = 2'd1,
        WORD        = 2'd2,
        DOUBLE_WORD = 2'd3
    } mem_access_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/sparrow_lsu_align.sv
// Lane steering for the LSU: store strobes/data shift-up, load shift-down and extend.
module sparrow_lsu_align
    import sparrow_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int BE_W  = DATA_W / 8,
    localparam int OFF_W = $clog2(BE_W)
) (
    input  mem_access_size_e   st_size,
    input  logic [OFF_W-1:0]   st_off,
    input  logic [DATA_W-1:0]  st_data,
    output logic [BE_W-1:0]    st_be,
    output logic [DATA_W-1:0]  st_data_sh,
    input  mem_access_size_e   ld_size,
    input  logic [OFF_W-1:0]   ld_off,
    input  logic               ld_zext,
    input  logic [DATA_W-1:0]  ld_raw,
    output logic [DATA_W-1:0]  ld_data
);

    logic [BE_W-1:0]   mask;
    logic [DATA_W-1:0] raw;
    logic              sign;
    int                nbytes;
    int                nbits;

    always_comb begin
        nbytes = 1 << st_size;
        mask   = '0;
        for (int i = 0; i < BE_W; i++)
            mask[i] = (i < nbytes);
        st_be      = mask << st_off;
        st_data_sh = st_data << {st_off, 3'b000};
    end

    // Width is clamped so an (already rejected) 64-bit size on a 32-bit bus stays in range.
    always_comb begin
        raw   = ld_raw >> {ld_off, 3'b000};
        nbits = 8 << ld_size;
        if (nbits > DATA_W)
            nbits = DATA_W;
        sign = 1'b0;
        for (int i = 0; i < DATA_W; i++)
            if (i == nbits - 1)
                sign = raw[i] & ~ld_zext;
        ld_data = '0;
        for (int i = 0; i < DATA_W; i++)
            ld_data[i] = (i < nbits) ? raw[i] : sign;
    end

endmodule

// File: rtl/sparrow_lsu.sv
// Load/store unit: alignment check, request/grant/response FSM and registered bus outputs.
module sparrow_lsu
    import sparrow_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 lsu_req_i,
    input  logic [ADDR_W-1:0]    lsu_addr_i,
    input  mem_access_size_e     lsu_size_i,
    input  logic                 lsu_wr_i,
    input  logic [DATA_W-1:0]    lsu_wr_data_i,
    input  logic                 lsu_zero_extnd_i,
    output logic                 lsu_busy_o,
    output logic                 lsu_done_o,
    output logic                 lsu_err_o,
    output logic [DATA_W-1:0]    lsu_rd_data_o,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [DATA_W/8-1:0]  mem_be_o,
    output logic                 mem_wr_o,
    output logic [DATA_W-1:0]    mem_wr_data_o,
    input  logic                 mem_rvalid_i,
    input  logic [DATA_W-1:0]    mem_rd_data_i
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);

    lsu_state_e        state;
    logic [OFF_W-1:0]  off_q;
    mem_access_size_e  size_q;
    logic              wr_q;
    logic              zext_q;
    logic              aligned;
    logic [BE_W-1:0]   st_be;
    logic [DATA_W-1:0] st_data_sh;
    logic [DATA_W-1:0] ld_data;

    always_comb begin
        unique case (lsu_size_i)
            BYTE:        aligned = 1'b1;
            HALF_WORD:   aligned = ~lsu_addr_i[0];
            WORD:        aligned = (lsu_addr_i[1:0] == 2'b00);
            DOUBLE_WORD: aligned = (DATA_W == 64) && (lsu_addr_i[2:0] == 3'b000);
            default:     aligned = 1'b0;
        endcase
    end

    sparrow_lsu_align #(.DATA_W(DATA_W)) u_align (
        .st_size    (lsu_size_i),
        .st_off     (lsu_addr_i[OFF_W-1:0]),
        .st_data    (lsu_wr_data_i),
        .st_be      (st_be),
        .st_data_sh (st_data_sh),
        .ld_size    (size_q),
        .ld_off     (off_q),
        .ld_zext    (zext_q),
        .ld_raw     (mem_rd_data_i),
        .ld_data    (ld_data)
    );

    assign lsu_busy_o = (state != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            off_q         <= '0;
            size_q        <= BYTE;
            wr_q          <= 1'b0;
            zext_q        <= 1'b0;
            lsu_done_o    <= 1'b0;
            lsu_err_o     <= 1'b0;
            lsu_rd_data_o <= '0;
            mem_req_o     <= 1'b0;
            mem_addr_o    <= '0;
            mem_be_o      <= '0;
            mem_wr_o      <= 1'b0;
            mem_wr_data_o <= '0;
        end else begin
            lsu_done_o <= 1'b0;
            lsu_err_o  <= 1'b0;
            unique case (state)
                IDLE: begin
                    lsu_rd_data_o <= '0;
                    if (lsu_req_i) begin
                        off_q  <= lsu_addr_i[OFF_W-1:0];
                        size_q <= lsu_size_i;
                        wr_q   <= lsu_wr_i;
                        zext_q <= lsu_zero_extnd_i;
                        if (aligned) begin
                            state         <= REQ;
                            mem_req_o     <= 1'b1;
                            mem_addr_o    <= {lsu_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_be_o      <= st_be;
                            mem_wr_o      <= lsu_wr_i;
                            mem_wr_data_o <= lsu_wr_i ? st_data_sh : '0;
                        end else begin
                            // Rejected without touching the bus; error completes next cycle.
                            lsu_done_o <= 1'b1;
                            lsu_err_o  <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        state         <= RESP;
                        mem_req_o     <= 1'b0;
                        mem_addr_o    <= '0;
                        mem_be_o      <= '0;
                        mem_wr_o      <= 1'b0;
                        mem_wr_data_o <= '0;
                    end
                end
                RESP: begin
                    if (mem_rvalid_i) begin
                        state         <= IDLE;
                        lsu_done_o    <= 1'b1;
                        lsu_rd_data_o <= wr_q ? '0 : ld_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sparrow_lsu.sv
// Directed bench for sparrow_lsu: a 32-bit instance for most vectors, a 64-bit one for wide lanes.
module tb_sparrow_lsu;
    import sparrow_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // 32-bit instance
    logic             req, wr, zext, busy, done, err, mreq, gnt, mwr, rvalid;
    logic [31:0]      addr, wdata, rd, maddr, mwdata, mrdata;
    logic [3:0]       be;
    mem_access_size_e size;

    // 64-bit instance
    logic             req64, wr64, zext64, busy64, done64, err64, mreq64, gnt64, mwr64, rvalid64;
    logic [31:0]      addr64, maddr64;
    logic [63:0]      wdata64, rd64, mwdata64, mrdata64;
    logic [7:0]       be64;
    mem_access_size_e size64;

    sparrow_lsu #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .lsu_req_i(req), .lsu_addr_i(addr), .lsu_size_i(size),
        .lsu_wr_i(wr), .lsu_wr_data_i(wdata), .lsu_zero_extnd_i(zext), .lsu_busy_o(busy),
        .lsu_done_o(done), .lsu_err_o(err), .lsu_rd_data_o(rd), .mem_req_o(mreq),
        .mem_gnt_i(gnt), .mem_addr_o(maddr), .mem_be_o(be), .mem_wr_o(mwr),
        .mem_wr_data_o(mwdata), .mem_rvalid_i(rvalid), .mem_rd_data_i(mrdata)
    );

    sparrow_lsu #(.DATA_W(64), .ADDR_W(32)) dut64 (
        .clk_i(clk), .rst_ni(rst_n), .lsu_req_i(req64), .lsu_addr_i(addr64), .lsu_size_i(size64),
        .lsu_wr_i(wr64), .lsu_wr_data_i(wdata64), .lsu_zero_extnd_i(zext64), .lsu_busy_o(busy64),
        .lsu_done_o(done64), .lsu_err_o(err64), .lsu_rd_data_o(rd64), .mem_req_o(mreq64),
        .mem_gnt_i(gnt64), .mem_addr_o(maddr64), .mem_be_o(be64), .mem_wr_o(mwr64),
        .mem_wr_data_o(mwdata64), .mem_rvalid_i(rvalid64), .mem_rd_data_i(mrdata64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One access on the 32-bit instance; inputs change and outputs are sampled on negedges.
    task automatic acc32(input string tag, input logic [31:0] a, input mem_access_size_e sz,
                         input logic w, input logic [31:0] wd, input logic zx,
                         input logic [31:0] mem_rd, input int gw, input int rw,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd,
                         input logic [31:0] exp_rd, input logic exp_err);
        @(negedge clk);
        req = 1'b1; addr = a; size = sz; wr = w; wdata = wd; zext = zx;
        @(negedge clk);
        req = 1'b0;
        if (exp_err) begin
            chk({tag, " err_req"},  {63'd0, mreq}, 64'd0);
            chk({tag, " err_done"}, {62'd0, done, err}, 64'd3);
            chk({tag, " err_rd"},   {32'd0, rd}, 64'd0);
            chk({tag, " err_busy"}, {63'd0, busy}, 64'd0);
            @(negedge clk);
            chk({tag, " err_pulse"}, {62'd0, done, err}, 64'd0);
            return;
        end
        for (int i = 0; i <= gw; i++) begin
            chk({tag, " req"},  {62'd0, mreq, done}, 64'd2);
            chk({tag, " addr"}, {32'd0, maddr}, {32'd0, a & 32'hFFFF_FFFC});
            chk({tag, " be"},   {60'd0, be}, {60'd0, exp_be});
            chk({tag, " wd"},   {31'd0, mwr, mwdata}, {31'd0, w, exp_wd});
            gnt = (i == gw);
            @(negedge clk);
        end
        gnt = 1'b0;
        for (int i = 0; i <= rw; i++) begin
            chk({tag, " resp"}, {61'd0, busy, mreq, done}, 64'd4);
            rvalid = (i == rw); mrdata = mem_rd;
            @(negedge clk);
        end
        rvalid = 1'b0;
        chk({tag, " done"}, {61'd0, busy, done, err}, 64'd2);
        chk({tag, " rd"},   {32'd0, rd}, {32'd0, exp_rd});
    endtask

    initial begin
        {req, wr, zext, gnt, rvalid} = '0;
        {req64, wr64, zext64, gnt64, rvalid64} = '0;
        addr = '0; wdata = '0; mrdata = '0; size = BYTE;
        addr64 = '0; wdata64 = '0; mrdata64 = '0; size64 = BYTE;
        #12;
        chk("reset32", {busy, done, err, mreq, mwr, be, maddr, rd}, 64'd0);
        chk("reset32_wd", {32'd0, mwdata}, 64'd0);
        chk("reset64", {busy64, done64, err64, mreq64, mwr64, be64, maddr64}, 64'd0);
        chk("reset64_data", rd64 | mwdata64, 64'd0);
        rst_n = 1'b1;

        acc32("ld_word",  32'h1000, WORD, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 0, 0,
              4'hF, 32'h0, 32'hDEADBEEF, 1'b0);
        acc32("ld_byte_s", 32'h1003, BYTE, 1'b0, 32'h0, 1'b0, 32'h80123456, 0, 0,
              4'h8, 32'h0, 32'hFFFFFF80, 1'b0);
        acc32("ld_byte_z", 32'h1003, BYTE, 1'b0, 32'h0, 1'b1, 32'h80123456, 0, 1,
              4'h8, 32'h0, 32'h00000080, 1'b0);
        acc32("st_half",  32'h2002, HALF_WORD, 1'b1, 32'h0000ABCD, 1'b0, 32'h5555AAAA, 3, 0,
              4'hC, 32'hABCD0000, 32'h0, 1'b0);
        acc32("ld_half_s", 32'h2002, HALF_WORD, 1'b0, 32'h0, 1'b0, 32'h9ABC1234, 1, 2,
              4'hC, 32'h0, 32'hFFFF9ABC, 1'b0);
        acc32("mis_word", 32'h1001, WORD, 1'b0, 32'h0, 1'b0, 32'h0, 0, 0,
              4'h0, 32'h0, 32'h0, 1'b1);
        acc32("mis_half", 32'h1003, HALF_WORD, 1'b1, 32'h1234, 1'b0, 32'h0, 0, 0,
              4'h0, 32'h0, 32'h0, 1'b1);
        acc32("dw_on_32", 32'h1000, DOUBLE_WORD, 1'b0, 32'h0, 1'b0, 32'h0, 0, 0,
              4'h0, 32'h0, 32'h0, 1'b1);

        // 64-bit bus: WORD load from the upper half
        @(negedge clk);
        req64 = 1'b1; addr64 = 32'h3004; size64 = WORD; wr64 = 1'b0; zext64 = 1'b0;
        @(negedge clk);
        req64 = 1'b0;
        chk("w64_req",  {63'd0, mreq64}, 64'd1);
        chk("w64_be",   {56'd0, be64}, 64'hF0);
        chk("w64_addr", {32'd0, maddr64}, 64'h3000);
        gnt64 = 1'b1;
        @(negedge clk);
        gnt64 = 1'b0; rvalid64 = 1'b1; mrdata64 = 64'h87654321_00000000;
        @(negedge clk);
        rvalid64 = 1'b0;
        chk("w64_done", {62'd0, done64, err64}, 64'd2);
        chk("w64_rd",   rd64, 64'hFFFFFFFF_87654321);

        // Reset while waiting for the response, then a stray rvalid
        @(negedge clk);
        req = 1'b1; addr = 32'h4000; size = WORD; wr = 1'b0; zext = 1'b0;
        @(negedge clk);
        req = 1'b0; gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        chk("rst_in_resp", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async", {busy, done, err, mreq, mwr, be, rd}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1; rvalid = 1'b1; mrdata = 32'h12345678;
        @(negedge clk);
        rvalid = 1'b0;
        chk("stray_rvalid", {62'd0, done, busy}, 64'd0);
        chk("stray_rd", {32'd0, rd}, 64'd0);
        acc32("after_rst", 32'h4000, WORD, 1'b0, 32'h0, 1'b1, 32'hCAFEF00D, 0, 0,
              4'hF, 32'h0, 32'hCAFEF00D, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sparrow_lsu.md
# sparrow_lsu

Parametrised load/store unit between the execute stage and the data-memory port, superseding the purely combinational data-memory pass-through. It accepts one load or store at a time and checks natural alignment. Byte strobes and write data are steered onto the correct lanes of a `DATA_W`-wide bus. It runs a request/grant/response handshake with memory that tolerates wait states, then returns lane-extracted, sign- or zero-extended read data with a completion pulse.

## Interface
- `DATA_W`, 32: memory and register data width; legal values 32 or 64.
- `ADDR_W`, 32: byte-address width.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_ni` in 1: asynchronous active-low reset.
- `lsu_req_i` in 1: request strobe, sampled only in IDLE.
- `lsu_addr_i` in `ADDR_W`: byte address.
- `lsu_size_i` in `mem_access_size_e`: BYTE, HALF_WORD, WORD, DOUBLE_WORD. DOUBLE_WORD is legal only when `DATA_W`=64.
- `lsu_wr_i` in 1: 1 = store, 0 = load.
- `lsu_wr_data_i` in `DATA_W`: store data, right-aligned.
- `lsu_zero_extnd_i` in 1: loads zero-extend when 1 and sign-extend when 0.
- `lsu_busy_o` out 1: high whenever state ≠ IDLE.
- `lsu_done_o` out 1: one-cycle completion pulse, for loads and stores alike.
- `lsu_err_o` out 1: one-cycle pulse, coincident with `lsu_done_o`, for a misaligned or illegal-size access.
- `lsu_rd_data_o` out `DATA_W`: extended load data, valid while `lsu_done_o`=1.
- `mem_req_o` out 1: memory request, held until granted.
- `mem_gnt_i` in 1: grant.
- `mem_addr_o` out `ADDR_W`: bus-aligned address, with the low log2(`DATA_W`/8) bits forced to 0.
- `mem_be_o` out `DATA_W`/8: byte strobes.
- `mem_wr_o` out 1: write enable.
- `mem_wr_data_o` out `DATA_W`: lane-shifted store data.
- `mem_rvalid_i` in 1: response valid, returned for both reads and writes.
- `mem_rd_data_i` in `DATA_W`: raw bus read data.

## Operation
- States: IDLE, REQ, RESP.
- Acceptance in IDLE with `lsu_req_i`=1 captures the following into registers:
  - `off = addr[log2(DATA_W/8)-1:0]`;
  - size, write flag, zero-extend flag;
  - aligned address, BE, and shifted write data.
- Alignment check: HALF_WORD needs `addr[0]`=0; WORD needs `addr[1:0]`=0; DOUBLE_WORD needs `addr[2:0]`=0 and `DATA_W`=64.
  - On failure: no memory request, state stays IDLE, and `lsu_done_o` and `lsu_err_o` pulse the next cycle with `lsu_rd_data_o`=0.
- Legal access, transitions:
  - IDLE→REQ on acceptance.
  - REQ→RESP on `mem_gnt_i`=1.
  - RESP→IDLE on `mem_rvalid_i`=1.
- Byte strobes: `mem_be_o` = (1/3/F/FF mask for B/H/W/D) << `off`.
- Write data: `mem_wr_data_o` = `lsu_wr_data_i` << 8·`off`.
- Load extraction: `raw = mem_rd_data_i >> 8·off`. Keep 8/16/32/64 bits per size, then zero- or sign-extend to `DATA_W`.
- Stores: `lsu_rd_data_o`=0.
- Stray inputs: `mem_gnt_i` outside REQ and `mem_rvalid_i` outside RESP are ignored.

## Timing
- Reset values: every output is 0; state = IDLE.
- Reset assertion mid-transaction drops `mem_req_o` immediately (asynchronously). A response arriving after reset is ignored.
- `mem_req_o`, `mem_addr_o`, `mem_be_o`, `mem_wr_o` and `mem_wr_data_o` are registered. They are driven only in REQ and are 0 otherwise. They are stable until the grant edge.
- Minimum latency, no wait states:
  - cycle 0: `lsu_req_i` accepted;
  - cycle 1: `mem_req_o`=1 and `mem_gnt_i`=1;
  - cycle 2: `mem_rvalid_i`=1;
  - cycle 3: `lsu_done_o`=1 with registered `lsu_rd_data_o`.
- Each grant wait state or response wait state adds exactly one cycle.
- `lsu_busy_o` is high in cycles 1–2 and low in the `lsu_done_o` cycle. A new request may be accepted in the done cycle, which gives back-to-back throughput of one access per 3 cycles.
- `lsu_req_i` while busy is ignored and is not queued.
- `lsu_done_o` never coincides with `mem_req_o` of the same transaction.

## Structure
- `sparrow_pkg` additions:
  - DOUBLE_WORD added to `mem_access_size_e`;
  - `lsu_state_e` (IDLE, REQ, RESP).
- Sub-module `sparrow_lsu_align`: combinational store lane-shift/strobe generation plus load extract/extend, parametrised by `DATA_W`. `sparrow_lsu` holds the FSM and registers.

## Test plan
- Aligned load, `DATA_W`=32, addr 0x1000, WORD, zero wait states, `mem_rd_data_i`=0xDEADBEEF: `mem_addr_o`=0x1000 and `mem_be_o`=0xF in cycle 1; `lsu_done_o` with 0xDEADBEEF in cycle 3.
- Byte load at addr 0x1003, sign-extend, `mem_rd_data_i`=0x80123456: `mem_be_o`=0x8 and `lsu_rd_data_o`=0xFFFFFF80. Repeated with zero-extend: 0x00000080.
- Half store at addr 0x2002, data 0x0000ABCD, 3 grant wait states: `mem_req_o` held 4 cycles with `mem_be_o`=0xC and `mem_wr_data_o`=0xABCD0000; `lsu_done_o` 2 cycles after the grant cycle.
- Misaligned WORD at 0x1001: `mem_req_o` stays 0; `lsu_done_o`=`lsu_err_o`=1 the next cycle with `lsu_rd_data_o`=0. DOUBLE_WORD at `DATA_W`=32 gives the same response.
- `DATA_W`=64, WORD load at 0x3004, sign-extend, `mem_rd_data_i`=0x87654321_00000000: `mem_be_o`=0xF0 and `lsu_rd_data_o`=0xFFFFFFFF_87654321.
- `rst_ni` pulsed while in RESP, followed by stray `mem_rvalid_i`: all outputs 0, no `lsu_done_o`, and the next request completes normally.
